// File: rtl/bsg_cam_tag_alloc_ctrl.sv
// Tag CAM allocation controller: serves one lookup at a time, allocates the
// lowest empty entry on a miss, evicts a round-robin victim when full, and
// handles single-entry frees and a walking flush.
//
// state  | meaning
// IDLE   | accepting flush, free or lookup (flush > free > lookup)
// LOOKUP | CAM read of tag_r; resolve hit / allocate / evict
// RESP   | response held on v_o until yumi_i
// FLUSH  | clear one entry per cycle, index 0..els_p-1
module bsg_cam_tag_alloc_ctrl #(
  parameter int width_p = 32,
  parameter int els_p   = 8,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 v_i,
  input  logic [width_p-1:0]   tag_i,
  output logic                 ready_o,
  output logic                 v_o,
  output logic                 hit_o,
  output logic [lg_els_lp-1:0] idx_o,
  output logic                 evict_v_o,
  output logic [width_p-1:0]   evict_tag_o,
  input  logic                 yumi_i,
  input  logic                 free_v_i,
  input  logic [lg_els_lp-1:0] free_idx_i,
  input  logic                 flush_i,
  output logic                 flush_done_o,
  output logic [els_p-1:0]     cam_w_v_o,
  output logic                 cam_w_set_not_clear_o,
  output logic [width_p-1:0]   cam_w_tag_o,
  input  logic [els_p-1:0]     cam_w_empty_i,
  output logic                 cam_r_v_o,
  output logic [width_p-1:0]   cam_r_tag_o,
  input  logic [els_p-1:0]     cam_r_match_i,
  output logic [lg_els_lp-1:0] cam_snoop_addr_o,
  input  logic [width_p-1:0]   cam_snoop_tag_i
);

  localparam logic [1:0] s_idle   = 2'd0;
  localparam logic [1:0] s_lookup = 2'd1;
  localparam logic [1:0] s_resp   = 2'd2;
  localparam logic [1:0] s_flush  = 2'd3;

  localparam logic [els_p-1:0]     one_lp  = els_p'(1);
  localparam logic [lg_els_lp-1:0] last_lp = lg_els_lp'(els_p - 1);

  logic [1:0]           state_r, state_n;
  logic [width_p-1:0]   tag_r, tag_n;
  logic [lg_els_lp-1:0] rr_r, rr_n;
  logic [lg_els_lp-1:0] cnt_r, cnt_n;
  logic [lg_els_lp-1:0] idx_r, idx_n;
  logic                 hit_r, hit_n;
  logic                 evict_r, evict_n;
  logic [width_p-1:0]   evict_tag_r, evict_tag_n;

  logic [lg_els_lp-1:0] match_idx, empty_idx;

  // Priority encoders: lowest set bit of the match and empty vectors.
  always_comb begin
    match_idx = '0;
    empty_idx = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (cam_r_match_i[i]) match_idx = lg_els_lp'(i);
      if (cam_w_empty_i[i]) empty_idx = lg_els_lp'(i);
    end
  end

  // Next-state logic and CAM control strobes.
  always_comb begin
    state_n               = state_r;
    tag_n                 = tag_r;
    rr_n                  = rr_r;
    cnt_n                 = cnt_r;
    idx_n                 = idx_r;
    hit_n                 = hit_r;
    evict_n               = evict_r;
    evict_tag_n           = evict_tag_r;
    ready_o               = 1'b0;
    flush_done_o          = 1'b0;
    cam_w_v_o             = '0;
    cam_w_set_not_clear_o = 1'b0;
    cam_r_v_o             = 1'b0;
    case (state_r)
      s_idle: begin
        ready_o = ~flush_i & ~free_v_i;
        if (flush_i) begin
          state_n = s_flush;
          cnt_n   = '0;
        end else if (free_v_i) begin
          cam_w_v_o = one_lp << free_idx_i;
        end else if (v_i) begin
          tag_n   = tag_i;
          state_n = s_lookup;
        end
      end
      s_lookup: begin
        cam_r_v_o = 1'b1;
        state_n   = s_resp;
        if (|cam_r_match_i) begin
          idx_n       = match_idx;
          hit_n       = 1'b1;
          evict_n     = 1'b0;
          evict_tag_n = '0;
        end else if (|cam_w_empty_i) begin
          idx_n                 = empty_idx;
          hit_n                 = 1'b0;
          evict_n               = 1'b0;
          evict_tag_n           = '0;
          cam_w_v_o             = one_lp << empty_idx;
          cam_w_set_not_clear_o = 1'b1;
        end else begin
          // Snoop returns the pre-write tag since the CAM updates at the edge.
          idx_n                 = rr_r;
          hit_n                 = 1'b0;
          evict_n               = 1'b1;
          evict_tag_n           = cam_snoop_tag_i;
          cam_w_v_o             = one_lp << rr_r;
          cam_w_set_not_clear_o = 1'b1;
          rr_n                  = (rr_r == last_lp) ? '0 : rr_r + 1'b1;
        end
      end
      s_resp: begin
        if (yumi_i) state_n = s_idle;
      end
      s_flush: begin
        cam_w_v_o = one_lp << cnt_r;
        if (cnt_r == last_lp) begin
          flush_done_o = 1'b1;
          rr_n         = '0;
          cnt_n        = '0;
          state_n      = s_idle;
        end else begin
          cnt_n = cnt_r + 1'b1;
        end
      end
      default: state_n = s_idle;
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= s_idle;
      tag_r       <= '0;
      rr_r        <= '0;
      cnt_r       <= '0;
      idx_r       <= '0;
      hit_r       <= 1'b0;
      evict_r     <= 1'b0;
      evict_tag_r <= '0;
    end else begin
      state_r     <= state_n;
      tag_r       <= tag_n;
      rr_r        <= rr_n;
      cnt_r       <= cnt_n;
      idx_r       <= idx_n;
      hit_r       <= hit_n;
      evict_r     <= evict_n;
      evict_tag_r <= evict_tag_n;
    end
  end

  // Response fields are only presented while the response is valid.
  assign v_o              = (state_r == s_resp);
  assign hit_o            = v_o & hit_r;
  assign idx_o            = v_o ? idx_r : '0;
  assign evict_v_o        = v_o & evict_r;
  assign evict_tag_o      = evict_v_o ? evict_tag_r : '0;
  assign cam_w_tag_o      = tag_r;
  assign cam_r_tag_o      = tag_r;
  assign cam_snoop_addr_o = rr_r;

`ifndef SYNTHESIS
  // Protocol sanity on the CAM interface.
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert ($countones(cam_r_match_i) <= 1);
      assert ($countones(cam_w_v_o) <= 1);
    end
  end
`endif

endmodule

// File: tb/tb_bsg_cam_tag_alloc_ctrl.sv
// Bench for bsg_cam_tag_alloc_ctrl: behavioural CAM attached to the DUT plus
// an independent allocation model (array of valid/tag + victim pointer).
module tb_bsg_cam_tag_alloc_ctrl;
  localparam int W = 32;
  localparam int N = 8;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          v_i, yumi_i, free_v_i, flush_i;
  logic [W-1:0]  tag_i;
  logic [2:0]    free_idx_i;
  logic          ready_o, v_o, hit_o, evict_v_o, flush_done_o;
  logic [2:0]    idx_o, cam_snoop_addr_o;
  logic [W-1:0]  evict_tag_o, cam_w_tag_o, cam_r_tag_o, cam_snoop_tag_i;
  logic [N-1:0]  cam_w_v_o, cam_w_empty_i, cam_r_match_i;
  logic          cam_w_set_not_clear_o, cam_r_v_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  bsg_cam_tag_alloc_ctrl #(.width_p(W), .els_p(N)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .v_i(v_i), .tag_i(tag_i), .ready_o(ready_o),
    .v_o(v_o), .hit_o(hit_o), .idx_o(idx_o),
    .evict_v_o(evict_v_o), .evict_tag_o(evict_tag_o), .yumi_i(yumi_i),
    .free_v_i(free_v_i), .free_idx_i(free_idx_i),
    .flush_i(flush_i), .flush_done_o(flush_done_o),
    .cam_w_v_o(cam_w_v_o), .cam_w_set_not_clear_o(cam_w_set_not_clear_o),
    .cam_w_tag_o(cam_w_tag_o), .cam_w_empty_i(cam_w_empty_i),
    .cam_r_v_o(cam_r_v_o), .cam_r_tag_o(cam_r_tag_o), .cam_r_match_i(cam_r_match_i),
    .cam_snoop_addr_o(cam_snoop_addr_o), .cam_snoop_tag_i(cam_snoop_tag_i)
  );

  // Behavioural CAM driven by the DUT's write port.
  logic [N-1:0] cv;
  logic [W-1:0] ct [N];

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cv <= '0;
      for (int i = 0; i < N; i++) ct[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (cam_w_v_o[i]) begin
          cv[i] <= cam_w_set_not_clear_o;
          if (cam_w_set_not_clear_o) ct[i] <= cam_w_tag_o;
        end
    end
  end

  always_comb begin
    cam_w_empty_i = ~cv;
    cam_r_match_i = '0;
    for (int i = 0; i < N; i++) cam_r_match_i[i] = cv[i] && (ct[i] == cam_r_tag_o);
    cam_snoop_tag_i = ct[cam_snoop_addr_o];
  end

  // Reference allocation model.
  bit           m_v [N];
  logic [W-1:0] m_t [N];
  int           m_rr;

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin m_v[i] = 0; m_t[i] = '0; end
    m_rr = 0;
  endtask

  task automatic model_lookup(input logic [W-1:0] t, output bit h, output int idx,
                              output bit ev, output logic [W-1:0] evt);
    h = 0; ev = 0; evt = '0; idx = -1;
    for (int i = 0; i < N; i++) if (m_v[i] && m_t[i] == t) begin h = 1; idx = i; end
    if (!h) begin
      for (int i = N - 1; i >= 0; i--) if (!m_v[i]) idx = i;
      if (idx < 0) begin
        idx = m_rr; ev = 1; evt = m_t[m_rr];
        m_rr = (m_rr + 1) % N;
      end
      m_v[idx] = 1; m_t[idx] = t;
    end
  endtask

  task automatic check_cam();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (cv[i] !== m_v[i] || (m_v[i] && ct[i] !== m_t[i])) begin
        n_fail++;
        $display("FAIL cam_entry[%0d]: got v=%0b tag=%h, want v=%0b tag=%h", i, cv[i], ct[i], m_v[i], m_t[i]);
      end
    end
  endtask

  task automatic do_req(input logic [W-1:0] t, input int stall);
    bit h, ev; int ei; logic [W-1:0] et; logic [N-1:0] ew;
    model_lookup(t, h, ei, ev, et);
    ew = h ? '0 : (N'(1) << ei);
    @(negedge clk_i); v_i = 1; tag_i = t; #1;
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL req_ready: got %b want 1", ready_o); end
    @(negedge clk_i); v_i = 0; tag_i = $urandom; #1;
    n_checks++;
    if (v_o !== 1'b0 || cam_r_v_o !== 1'b1 || cam_r_tag_o !== t) begin
      n_fail++;
      $display("FAIL lookup_cycle: got v_o=%b r_v=%b r_tag=%h want 0 1 %h", v_o, cam_r_v_o, cam_r_tag_o, t);
    end
    n_checks++;
    if (cam_w_v_o !== ew || (!h && cam_w_set_not_clear_o !== 1'b1)) begin
      n_fail++;
      $display("FAIL lookup_write: got w_v=%b set=%b want w_v=%b", cam_w_v_o, cam_w_set_not_clear_o, ew);
    end
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk_i); #1;
      n_checks++;
      if (v_o !== 1'b1 || hit_o !== h || idx_o !== 3'(ei) || evict_v_o !== ev ||
          evict_tag_o !== (ev ? et : '0) || ready_o !== 1'b0 || cam_r_v_o !== 1'b0) begin
        n_fail++;
        $display("FAIL resp tag=%h cyc=%0d: got v=%b hit=%b idx=%0d ev=%b evt=%h rdy=%b, want 1 %b %0d %b %h 0",
                 t, s, v_o, hit_o, idx_o, evict_v_o, evict_tag_o, ready_o, h, ei, ev, ev ? et : '0);
      end
    end
    yumi_i = 1;
    @(negedge clk_i); yumi_i = 0; #1;
    n_checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++; $display("FAIL after_yumi: got v_o=%b ready=%b want 0 1", v_o, ready_o);
    end
    check_cam();
  endtask

  task automatic do_free(input int k);
    @(negedge clk_i); free_v_i = 1; free_idx_i = 3'(k); #1;
    n_checks++;
    if (ready_o !== 1'b0 || cam_w_v_o !== (N'(1) << k) || cam_w_set_not_clear_o !== 1'b0) begin
      n_fail++;
      $display("FAIL free[%0d]: got rdy=%b w_v=%b set=%b", k, ready_o, cam_w_v_o, cam_w_set_not_clear_o);
    end
    @(negedge clk_i); free_v_i = 0; #1;
    m_v[k] = 0;
    check_cam();
  endtask

  task automatic do_flush(input bit with_others);
    @(negedge clk_i);
    flush_i = 1;
    if (with_others) begin v_i = 1; tag_i = 32'hDEAD; free_v_i = 1; free_idx_i = 3'd5; end
    #1;
    n_checks++;
    if (ready_o !== 1'b0 || cam_w_v_o !== '0) begin
      n_fail++; $display("FAIL flush_start: got ready=%b w_v=%b want 0 0", ready_o, cam_w_v_o);
    end
    for (int k = 0; k < N; k++) begin
      @(negedge clk_i); #1;
      n_checks++;
      if (cam_w_v_o !== (N'(1) << k) || cam_w_set_not_clear_o !== 1'b0 ||
          flush_done_o !== (k == N - 1) || ready_o !== 1'b0 || v_o !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_step[%0d]: got w_v=%b set=%b done=%b rdy=%b", k, cam_w_v_o,
                 cam_w_set_not_clear_o, flush_done_o, ready_o);
      end
      if (k == N - 1) begin flush_i = 0; v_i = 0; free_v_i = 0; end
    end
    @(negedge clk_i); #1;
    n_checks++;
    if (flush_done_o !== 1'b0 || ready_o !== 1'b1 || cam_w_v_o !== '0) begin
      n_fail++; $display("FAIL flush_end: got done=%b ready=%b w_v=%b", flush_done_o, ready_o, cam_w_v_o);
    end
    model_clear();
    check_cam();
  endtask

  task automatic test_reset();
    n_checks++;
    if (ready_o !== 1'b1 || v_o !== 1'b0 || hit_o !== 1'b0 || idx_o !== '0 || evict_v_o !== 1'b0 ||
        evict_tag_o !== '0 || flush_done_o !== 1'b0 || cam_w_v_o !== '0 || cam_r_v_o !== 1'b0 ||
        cam_snoop_addr_o !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b v=%b hit=%b idx=%0d ev=%b done=%b w_v=%b r_v=%b snoop=%0d",
               ready_o, v_o, hit_o, idx_o, evict_v_o, flush_done_o, cam_w_v_o, cam_r_v_o, cam_snoop_addr_o);
    end
    check_cam();
  endtask

  task automatic test_basic();
    do_req(32'hA5, 0);
    do_req(32'hA5, 0);
    do_req(32'h11, 1);
  endtask

  task automatic test_fill_evict();
    do_flush(0);
    for (int i = 0; i < N; i++) do_req(32'h100 + i, 0);
    do_req(32'h200, 0);
    do_req(32'h201, 0);
    for (int i = 0; i < N; i++) do_req(32'h210 + i, 0);
  endtask

  task automatic test_free();
    do_free(3);
    do_req(32'h400, 0);
    do_req(32'h401, 0);
    do_free(3);
    do_free(3);
  endtask

  task automatic test_flush_priority();
    do_flush(1);
    do_req(32'h500, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 80; it++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 3) do_free($urandom_range(0, N - 1));
      else if (r == 3) do_flush($urandom_range(0, 1));
      else do_req(32'h300 + $urandom_range(0, 11), $urandom_range(0, 3));
    end
  endtask

  task automatic test_stall_reset();
    bit h, ev; int ei; logic [W-1:0] et;
    model_lookup(32'h777, h, ei, ev, et);
    @(negedge clk_i); v_i = 1; tag_i = 32'h777;
    @(negedge clk_i); v_i = 0;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk_i); #1;
      n_checks++;
      if (v_o !== 1'b1 || hit_o !== h || idx_o !== 3'(ei) || evict_v_o !== ev ||
          evict_tag_o !== (ev ? et : '0) || ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stall[%0d]: got v=%b hit=%b idx=%0d ev=%b rdy=%b want 1 %b %0d %b 0",
                 s, v_o, hit_o, idx_o, evict_v_o, ready_o, h, ei, ev);
      end
    end
    reset_i = 1; #1;
    n_checks++;
    if (v_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid_resp: got v_o=%b want 0", v_o); end
    model_clear();
    repeat (2) @(negedge clk_i);
    reset_i = 0; #1;
    n_checks++;
    if (ready_o !== 1'b1 || v_o !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got ready=%b v_o=%b want 1 0", ready_o, v_o);
    end
    check_cam();
    do_req(32'h778, 0);
  endtask

  initial begin
    reset_i = 1; v_i = 0; tag_i = '0; yumi_i = 0; free_v_i = 0; free_idx_i = '0; flush_i = 0;
    model_clear();
    repeat (3) @(negedge clk_i);
    reset_i = 0; #1;
    test_reset();
    test_basic();
    test_fill_evict();
    test_free();
    test_flush_priority();
    test_random();
    test_stall_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
